// File: rtl/gb_fetch_pkg.sv
// Shared types and constants for the opcode fetch front-end.
package gb_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_PREFIX = 2'd2,
        ST_HOLD   = 2'd3
    } fetch_state_t;

    // Byte that selects the extended (page-1) opcode table
    localparam logic [7:0] PREFIX_BYTE_DEF = 8'hCB;

    // {prefix_flag, byte} index into the microcode ROM
    localparam int unsigned OPCODE_W = 9;

    localparam logic [OPCODE_W-1:0] NOP_OPCODE = '0;

    // Unprefixed bytes with no defined instruction
    localparam int unsigned N_ILLEGAL = 11;
    localparam logic [N_ILLEGAL*8-1:0] ILLEGAL_OPS = {
        8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
        8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD
    };

endpackage

// File: rtl/opcode_fetch_mod_illegal_op_chk.sv
// Combinational check: flags bytes that have no unprefixed instruction.
module illegal_op_chk
    import gb_fetch_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_illegal
);

    // Match the byte against every entry of the illegal list
    always_comb begin
        o_illegal = 1'b0;
        for (int unsigned i = 0; i < N_ILLEGAL; i++) begin
            if (ILLEGAL_OPS[i*8 +: 8] == i_byte) begin
                o_illegal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/opcode_fetch_mod.sv
// Opcode fetch front-end: reads instruction bytes, folds the prefix byte
// into a 9-bit microcode index and holds it under a valid/ready handshake.
// Optional illegal-opcode detection: define OPCODE_FETCH_ILLEGAL_EN.
module opcode_fetch_mod
    import gb_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter logic [7:0]  PREFIX_BYTE = PREFIX_BYTE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                flush,
    output logic                mem_rd_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_rd_ack,
    input  logic [7:0]          mem_rd_data,
    output logic                pc_inc,
    output logic [OPCODE_W-1:0] opcode,
    output logic                opcode_valid,
    input  logic                opcode_ready,
`ifdef OPCODE_FETCH_ILLEGAL_EN
    output logic                illegal_op,
`endif
    output logic                busy
);

    fetch_state_t        r_state;
    fetch_state_t        w_next_state;
    logic [ADDR_W-1:0]   r_fetch_addr;
    logic [OPCODE_W-1:0] r_opcode;
    logic                r_pc_inc;

    logic                w_reading;
    logic                w_take;
    logic                w_accept;
    logic                w_start;
    logic                w_is_prefix;
    logic                w_load_op;
    logic [OPCODE_W-1:0] w_fetch_op;
    logic [OPCODE_W-1:0] w_new_op;

    // A byte is consumed only while reading and not flushed the same cycle
    assign w_reading   = (r_state == ST_FETCH) || (r_state == ST_PREFIX);
    assign w_take      = w_reading && mem_rd_ack && !flush;
    assign w_accept    = (r_state == ST_HOLD) && opcode_ready;
    assign w_start     = !flush && fetch_req && ((r_state == ST_IDLE) || w_accept);
    assign w_is_prefix = (mem_rd_data == PREFIX_BYTE);
    // In PREFIX a second prefix byte is an ordinary page-1 index
    assign w_load_op   = w_take && ((r_state == ST_PREFIX) || !w_is_prefix);
    assign w_new_op    = (r_state == ST_PREFIX) ? {1'b1, mem_rd_data} : w_fetch_op;

`ifdef OPCODE_FETCH_ILLEGAL_EN
    logic w_illegal;
    logic r_illegal;

    illegal_op_chk u_illegal_op_chk (
        .i_byte    (mem_rd_data),
        .o_illegal (w_illegal)
    );

    assign w_fetch_op = w_illegal ? NOP_OPCODE : {1'b0, mem_rd_data};
    assign illegal_op = r_illegal;

    // Illegal flag rides along with the opcode until accepted or flushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (flush || w_accept) begin
            r_illegal <= 1'b0;
        end else if (w_load_op) begin
            r_illegal <= w_illegal && (r_state == ST_FETCH);
        end
    end
`else
    assign w_fetch_op = {1'b0, mem_rd_data};
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides every other condition
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (fetch_req) w_next_state = ST_FETCH;
                ST_FETCH:  if (mem_rd_ack) w_next_state = w_is_prefix ? ST_PREFIX : ST_HOLD;
                ST_PREFIX: if (mem_rd_ack) w_next_state = ST_HOLD;
                ST_HOLD:   if (opcode_ready) w_next_state = fetch_req ? ST_FETCH : ST_IDLE;
                default:   w_next_state = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state plus the registered datapath
    always_comb begin
        mem_rd_req   = w_reading;
        opcode_valid = (r_state == ST_HOLD);
        busy         = (r_state != ST_IDLE);
        mem_addr     = r_fetch_addr;
        opcode       = r_opcode;
        pc_inc       = r_pc_inc;
    end

    // Fetch address, opcode latch and the pc_inc pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_addr <= '0;
            r_opcode     <= '0;
            r_pc_inc     <= 1'b0;
        end else begin
            r_pc_inc <= w_take;
            if (w_start) begin
                r_fetch_addr <= pc;
            end else if (w_take) begin
                r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
            end
            if (w_load_op) begin
                r_opcode <= w_new_op;
            end
        end
    end

endmodule

// File: tb/tb_opcode_fetch_mod.sv
// Scoreboard bench for opcode_fetch_mod: a byte-array memory model answers
// reads with random wait states; expected opcodes, read addresses and
// pc_inc counts are derived from the memory contents.
module tb_opcode_fetch_mod;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] pc;
    logic        flush;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic        mem_rd_ack;
    logic [7:0]  mem_rd_data;
    logic        pc_inc;
    logic [8:0]  opcode;
    logic        opcode_valid;
    logic        opcode_ready;
    logic        busy;
`ifdef OPCODE_FETCH_ILLEGAL_EN
    logic        illegal_op;
`endif

    opcode_fetch_mod #(.ADDR_W(16), .PREFIX_BYTE(8'hCB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req    (fetch_req),
        .pc           (pc),
        .flush        (flush),
        .mem_rd_req   (mem_rd_req),
        .mem_addr     (mem_addr),
        .mem_rd_ack   (mem_rd_ack),
        .mem_rd_data  (mem_rd_data),
        .pc_inc       (pc_inc),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .opcode_ready (opcode_ready),
`ifdef OPCODE_FETCH_ILLEGAL_EN
        .illegal_op   (illegal_op),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [65536];
    logic [9:0]  exp_q [$];       // {illegal, opcode}
    logic [15:0] exp_addr_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_inc  = 0;
    int          got_inc  = 0;
    int          rsp_delay = -1;  // <0: random 0..3 wait cycles
    bit          rsp_en   = 1'b1;
    logic        man_ack  = 1'b0;
    logic [7:0]  man_data = 8'h00;
    logic [9:0]  last_exp;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, want, $time);
        end
    endtask

`ifdef OPCODE_FETCH_ILLEGAL_EN
    function automatic bit is_illegal(input logic [7:0] b);
        case (b)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Reference: what an instruction at address a must decode to
    function automatic logic [9:0] model(input logic [15:0] a, output bit pfx);
        logic [15:0] a1;
        logic [7:0]  b0;
        a1  = a + 16'd1;
        b0  = mem[a];
        pfx = (b0 == 8'hCB);
        if (pfx) return {1'b0, 1'b1, mem[a1]};
`ifdef OPCODE_FETCH_ILLEGAL_EN
        if (is_illegal(b0)) return {1'b1, 9'h000};
`endif
        return {1'b0, 1'b0, b0};
    endfunction

    // Memory responder: acks each request after a chosen number of wait states
    initial begin
        int  cnt = 0;
        bit  in_req = 1'b0;
        mem_rd_ack  = 1'b0;
        mem_rd_data = 8'h00;
        forever begin
            @(negedge clk);
            #2;
            mem_rd_ack = 1'b0;
            if (!rsp_en) begin
                mem_rd_ack  = man_ack;
                mem_rd_data = man_data;
                in_req      = 1'b0;
            end else if (mem_rd_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    cnt = (rsp_delay < 0) ? int'($urandom_range(0, 3)) : rsp_delay;
                end
                if (cnt == 0) begin
                    mem_rd_ack  = 1'b1;
                    mem_rd_data = mem[mem_addr];
                    in_req      = 1'b0;
                    if (exp_addr_q.size() == 0) chk("unexpected_read", 32'(mem_addr), 32'hFFFF_FFFF);
                    else chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                end else begin
                    cnt--;
                end
            end else begin
                in_req = 1'b0;
            end
        end
    end

    // Monitor: counts pc_inc pulses and checks each accepted opcode
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && pc_inc) got_inc++;
            if (rst_n && opcode_valid && opcode_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_opcode", 32'(opcode), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("opcode", 32'(opcode), 32'(e[8:0]));
`ifdef OPCODE_FETCH_ILLEGAL_EN
                    chk("illegal_op", 32'(illegal_op), 32'(e[9]));
`endif
                end
            end
        end
    end

    // Issue a fetch. Entered at a negedge with the DUT idle, or (b2b) in HOLD
    // with opcode_ready already high; returns with the opcode presented and
    // opcode_ready high for the coming edge.
    task automatic txn(input logic [15:0] a, input bit b2b, input int stall);
        bit         pfx;
        int         n;
        int         k;
        logic [9:0] e;
        e = model(a, pfx);
        exp_q.push_back(e);
        exp_addr_q.push_back(a);
        if (pfx) exp_addr_q.push_back(a + 16'd1);
        exp_inc += pfx ? 2 : 1;
        last_exp = e;
        pc = a;
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req    = 1'b0;
        opcode_ready = 1'b0;
        if (b2b) chk("b2b_rd_req", 32'(mem_rd_req), 32'd1);
        n = 0;
        while (!opcode_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!opcode_valid) begin
            chk("valid_timeout", 32'(n), 32'd0);
        end else if (rsp_delay >= 0) begin
            chk("latency", 32'(n), pfx ? 32'(2 * rsp_delay + 2) : 32'(rsp_delay + 1));
        end
        k = (stall < 0) ? int'($urandom_range(0, 5)) : stall;
        repeat (k) begin
            chk("hold_opcode", 32'(opcode), 32'(e[8:0]));
            chk("hold_valid", 32'(opcode_valid), 32'd1);
            @(negedge clk);
        end
        opcode_ready = 1'b1;
    endtask

    // Accept the presented opcode without a follow-on fetch
    task automatic finish_idle();
        @(negedge clk);
        opcode_ready = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(opcode_valid), 32'd0);
        chk("opcode_kept", 32'(opcode), 32'(last_exp[8:0]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          pend;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0; fetch_req = 1'b0; pc = '0; flush = 1'b0; opcode_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd_req", 32'(mem_rd_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_pc_inc", 32'(pc_inc), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_valid", 32'(opcode_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain fetch, zero wait states, long stall
        rsp_delay = 0;
        mem[16'h0150] = 8'h3E;
        txn(16'h0150, 1'b0, 5);
        finish_idle();

        // Prefixed fetches with 3 wait states, then back-to-back and wrap
        rsp_delay = 3;
        mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h7C;
        txn(16'h0200, 1'b0, -1);
        finish_idle();
        mem[16'h0300] = 8'hCB; mem[16'h0301] = 8'hCB;
        txn(16'h0300, 1'b0, -1);
        mem[16'h0400] = 8'h00;
        txn(16'h0400, 1'b1, -1);
        mem[16'hFFFF] = 8'hCB; mem[16'h0000] = 8'h12;
        txn(16'hFFFF, 1'b1, -1);
        finish_idle();
`ifdef OPCODE_FETCH_ILLEGAL_EN
        mem[16'h0500] = 8'hD3;
        txn(16'h0500, 1'b0, 2);
        finish_idle();
        mem[16'h0600] = 8'hCB; mem[16'h0601] = 8'hD3;
        txn(16'h0600, 1'b0, 2);
        finish_idle();
`endif

        // Randomized traffic
        rsp_delay = -1;
        pend = 1'b0;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            if ($urandom_range(0, 2) == 0) mem[a] = 8'hCB;
            if ($urandom_range(0, 4) == 0) mem[a + 16'd1] = 8'hCB;
            if (pend && $urandom_range(0, 1) == 0) begin
                finish_idle();
                pend = 1'b0;
            end
            txn(a, pend, -1);
            pend = 1'b1;
        end
        if (pend) finish_idle();

        // Flush colliding with a read ack
        rsp_en = 1'b0;
        pc = 16'h3000; fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        chk("flush_rd_req", 32'(mem_rd_req), 32'd1);
        chk("flush_addr", 32'(mem_addr), 32'h3000);
        man_ack = 1'b1; man_data = 8'h55; flush = 1'b1;
        @(negedge clk);
        man_ack = 1'b0; flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_rd_req_low", 32'(mem_rd_req), 32'd0);
        chk("flush_valid", 32'(opcode_valid), 32'd0);
        chk("flush_pc_inc", 32'(pc_inc), 32'd0);
        @(negedge clk);
        chk("flush_pc_inc2", 32'(pc_inc), 32'd0);
        chk("flush_valid2", 32'(opcode_valid), 32'd0);

        // Flush together with fetch_req in IDLE
        pc = 16'h4000; fetch_req = 1'b1; flush = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", 32'(busy), 32'd0);
        chk("flush_idle_rd_req", 32'(mem_rd_req), 32'd0);
        @(negedge clk);
        chk("flush_idle_busy2", 32'(busy), 32'd0);

        // Reset asserted while a read is outstanding
        pc = 16'h1234; fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        chk("pre_rst_rd_req", 32'(mem_rd_req), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_rd_req", 32'(mem_rd_req), 32'd0);
        chk("midrst_valid", 32'(opcode_valid), 32'd0);
        chk("midrst_pc_inc", 32'(pc_inc), 32'd0);
        chk("midrst_opcode", 32'(opcode), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("pc_inc_count", 32'(got_inc), 32'(exp_inc));
        chk("opcodes_left", 32'(exp_q.size()), 32'd0);
        chk("reads_left", 32'(exp_addr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/opcode_fetch_mod.md
Name: opcode_fetch_mod

Overview:
Fetch front-end of the CPU core. It reads instruction bytes from the memory bus, folds the 0xCB prefix into a 9-bit opcode index, and presents that index to the microcode ROM stage.
The microcode ROM maps the 9-bit index to the 62-bit control word.
The block holds the index stable with a valid/ready handshake until the sequencer accepts it, and pulses a PC-increment request per byte consumed.

Parameters:
ADDR_W, 16, width of fetch address / PC.
PREFIX_BYTE, 8'hCB, byte value that selects the extended opcode page.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_req  input  1  sequencer requests the next instruction; sampled only in IDLE or on a HOLD handshake cycle
pc  input  ADDR_W  current program counter; captured on an accepted fetch_req
flush  input  1  abort the in-flight fetch (jump/interrupt), synchronous, highest priority
mem_rd_req  output  1  memory read request, held until ack
mem_addr  output  ADDR_W  read address, stable while mem_rd_req=1
mem_rd_ack  input  1  read data valid this cycle; ignored when mem_rd_req=0
mem_rd_data  input  8  read byte, sampled when mem_rd_req & mem_rd_ack
pc_inc  output  1  one-cycle pulse per byte consumed
opcode  output  9  {prefix_flag, byte}; index into the microcode ROM
opcode_valid  output  1  opcode is stable and usable
opcode_ready  input  1  consumer accepts opcode when opcode_valid & opcode_ready
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE
  - mem_rd_req=0, mem_addr=0, pc_inc=0
  - opcode=9'h000, opcode_valid=0, busy=0
- States: IDLE, FETCH, PREFIX, HOLD. The state register and the fetch_addr register are internal.
- IDLE:
  - fetch_req=1 → fetch_addr<=pc, go to FETCH.
  - mem_rd_req rises on the next cycle (latency 1).
- FETCH:
  - mem_rd_req=1 and mem_addr=fetch_addr until mem_rd_ack.
  - On ack: pc_inc=1 for the next cycle only, and fetch_addr<=fetch_addr+1 (wraps all-ones→0).
  - If mem_rd_data==PREFIX_BYTE → go to PREFIX. mem_rd_req stays high with the new address, with no idle cycle.
  - Otherwise opcode<={1'b0,data}, opcode_valid<=1, go to HOLD.
- PREFIX:
  - Same read rule as FETCH.
  - On ack: pc_inc pulse, opcode<={1'b1,data}, go to HOLD.
  - A second 0xCB byte is a legal page-1 index (9'h1CB) and is not re-treated as a prefix.
- HOLD:
  - opcode and opcode_valid stay stable; mem_rd_req=0.
  - On opcode_valid & opcode_ready:
    - if fetch_req=1 the same cycle → capture pc and go to FETCH (back-to-back);
    - otherwise go to IDLE with opcode_valid<=0.
  - opcode keeps its last value after acceptance.
- Latency: ack at cycle M → opcode_valid=1 at M+1. A prefixed instruction costs two read transactions.
- flush=1 in any state:
  - next state IDLE; mem_rd_req<=0, opcode_valid<=0, pc_inc<=0.
  - A mem_rd_ack arriving in the same cycle is discarded.
  - flush wins over a simultaneous fetch_req or handshake.
- fetch_req in FETCH/PREFIX is ignored (no queueing).
- Prefix byte at address all-ones: the second byte is read from address 0.
- Reset asserted mid-transaction: request dropped immediately (async). No pc_inc is emitted.

Optional Feature:
Macro OPCODE_FETCH_ILLEGAL_EN.
- Defined:
  - Adds output illegal_op (1 bit).
  - Unprefixed bytes D3, DB, DD, E3, E4, EB, EC, ED, F4, FC, FD set illegal_op=1 together with opcode_valid. The flag is held through HOLD and cleared on acceptance, flush, or reset.
  - opcode is replaced by 9'h000 (NOP).
- Undefined: port absent; all bytes pass through unchanged.

Decomposition:
- Package gb_fetch_pkg holds:
  - the state enum (IDLE/FETCH/PREFIX/HOLD);
  - the PREFIX_BYTE default;
  - the OPCODE_W=9 constant;
  - the illegal-opcode list constant.
- One natural sub-module: illegal_op_chk, a combinational byte→flag check. It is instantiated only under the macro.

Test Plan:
- Reset mid-FETCH:
  - Stimulus: rst_n=0 while mem_rd_req=1.
  - Response: mem_rd_req, opcode_valid and pc_inc are 0 immediately, and opcode=9'h000.
- Plain fetch, no wait states:
  - Stimulus: pc=16'h0150, fetch_req, ack one cycle after request with data 8'h3E.
  - Response: mem_addr=0150, one pc_inc pulse, opcode=9'h03E valid one cycle after ack.
  - With opcode_ready held 0 for 5 cycles, opcode stays stable.
- Prefixed fetch with wait states:
  - Stimulus: data CB then 7C, each ack delayed 3 cycles.
  - Response: addresses 0200 then 0201, two pc_inc pulses, opcode=9'h17C.
  - A second CB byte yields 9'h1CB.
- Back-to-back and wrap:
  - Stimulus: accept with fetch_req high in the same cycle.
  - Response: next mem_rd_req asserted the following cycle with no IDLE cycle.
  - Prefix at FFFF reads its second byte from 0000.
- Flush collisions:
  - Stimulus: flush coincident with mem_rd_ack; separately, flush together with fetch_req in IDLE.
  - Response: no opcode_valid and no pc_inc; block stays in IDLE.
- With OPCODE_FETCH_ILLEGAL_EN:
  - Stimulus: byte D3.
  - Response: illegal_op=1, opcode=9'h000.
  - Byte CB followed by D3 → opcode=9'h1D3 with illegal_op=0.
